// File: rtl/vproc_bus_arbiter.sv
// vproc_bus_arbiter: round-robin share of one VProc slave bus among masters.
// Ports: Clk/nReset, packed per-master M* bus in, S* slave bus out,
//   SWRAck/SRDAck routed to the grantee only, GrantValid/GrantIdx status.
module vproc_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_WIDTH   = 2
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [32*NUM_MASTERS-1:0] MAddr,
  input  logic [4*NUM_MASTERS-1:0]  MBE,
  input  logic [NUM_MASTERS-1:0]    MWE,
  input  logic [NUM_MASTERS-1:0]    MRD,
  input  logic [32*NUM_MASTERS-1:0] MDataOut,
  input  logic [12*NUM_MASTERS-1:0] MBurst,
  input  logic [NUM_MASTERS-1:0]    MBurstFirst,
  input  logic [NUM_MASTERS-1:0]    MBurstLast,
  output logic [31:0]               MDataIn,
  output logic [NUM_MASTERS-1:0]    MWRAck,
  output logic [NUM_MASTERS-1:0]    MRDAck,
  output logic [31:0]               SAddr,
  output logic [3:0]                SBE,
  output logic                      SWE,
  output logic                      SRD,
  output logic [31:0]               SDataOut,
  output logic [11:0]               SBurst,
  output logic                      SBurstFirst,
  output logic                      SBurstLast,
  input  logic [31:0]               SDataIn,
  input  logic                      SWRAck,
  input  logic                      SRDAck,
  output logic                      GrantValid,
  output logic [IDX_WIDTH-1:0]      GrantIdx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_WIDTH-1:0]   grant;
  logic [IDX_WIDTH-1:0]   last_idx;
  logic [IDX_WIDTH-1:0]   pick;
  logic [IDX_WIDTH-1:0]   cidx;
  logic                   pick_ok;
  logic [11:0]            ack_cnt;
  logic [11:0]            burst_len;
  logic [11:0]            pick_burst;
  logic [NUM_MASTERS-1:0] req;
  logic                   busy;
  logic                   ack_hit;
  logic                   last_ack;
  int                     cand;

  assign req     = MWE | MRD;
  assign busy    = (state == BUSY);
  assign MDataIn = SDataIn;

  assign GrantValid = busy;
  assign GrantIdx   = grant;

  // Scan from the highest offset down so the last hit is the
  // nearest requester after last_idx (last grantee gets lowest priority).
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = (int'(last_idx) + k) % NUM_MASTERS;
      cidx = IDX_WIDTH'(cand);
      if (req[cidx]) begin
        pick    = cidx;
        pick_ok = 1'b1;
      end
    end
  end

  assign pick_burst = MBurst[12*pick +: 12];

  // A cycle with both acks counts once.
  assign ack_hit  = busy & ((SWE & SWRAck) | (SRD & SRDAck));
  assign last_ack = ack_hit & ((ack_cnt + 12'd1) == burst_len);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pick_ok) state_nxt = BUSY;
      BUSY: if (!req[grant] || last_ack) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    SAddr       = '0;
    SBE         = '0;
    SWE         = 1'b0;
    SRD         = 1'b0;
    SDataOut    = '0;
    SBurst      = '0;
    SBurstFirst = 1'b0;
    SBurstLast  = 1'b0;
    MWRAck      = '0;
    MRDAck      = '0;
    if (busy) begin
      SAddr          = MAddr[32*grant +: 32];
      SBE            = MBE[4*grant +: 4];
      SWE            = MWE[grant];
      SRD            = MRD[grant];
      SDataOut       = MDataOut[32*grant +: 32];
      SBurst         = MBurst[12*grant +: 12];
      SBurstFirst    = MBurstFirst[grant];
      SBurstLast     = MBurstLast[grant];
      MWRAck[grant]  = SWRAck & MWE[grant];
      MRDAck[grant]  = SRDAck & MRD[grant];
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      grant     <= '0;
      last_idx  <= IDX_WIDTH'(NUM_MASTERS - 1);
      ack_cnt   <= '0;
      burst_len <= 12'd1;
    end else if (!busy) begin
      if (pick_ok) begin
        grant     <= pick;
        last_idx  <= pick;
        ack_cnt   <= '0;
        burst_len <= (pick_burst == 12'd0) ? 12'd1 : pick_burst;
      end
    end else if (ack_hit) begin
      ack_cnt <= ack_cnt + 12'd1;
    end
  end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// tb_vproc_bus_arbiter: directed scenarios for the VProc bus arbiter.
// Drives/samples 1 time unit after posedge; slave acks come from the bench.
module tb_vproc_bus_arbiter;
  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          nReset;
  logic [32*N-1:0] MAddr;
  logic [4*N-1:0]  MBE;
  logic [N-1:0]    MWE;
  logic [N-1:0]    MRD;
  logic [32*N-1:0] MDataOut;
  logic [12*N-1:0] MBurst;
  logic [N-1:0]    MBurstFirst;
  logic [N-1:0]    MBurstLast;
  logic [31:0]     MDataIn;
  logic [N-1:0]    MWRAck;
  logic [N-1:0]    MRDAck;
  logic [31:0]     SAddr;
  logic [3:0]      SBE;
  logic            SWE;
  logic            SRD;
  logic [31:0]     SDataOut;
  logic [11:0]     SBurst;
  logic            SBurstFirst;
  logic            SBurstLast;
  logic [31:0]     SDataIn;
  logic            SWRAck;
  logic            SRDAck;
  logic            GrantValid;
  logic [1:0]      GrantIdx;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  vproc_bus_arbiter #(.NUM_MASTERS(N), .IDX_WIDTH(2)) dut (
    .Clk(Clk), .nReset(nReset),
    .MAddr(MAddr), .MBE(MBE), .MWE(MWE), .MRD(MRD),
    .MDataOut(MDataOut), .MBurst(MBurst),
    .MBurstFirst(MBurstFirst), .MBurstLast(MBurstLast),
    .MDataIn(MDataIn), .MWRAck(MWRAck), .MRDAck(MRDAck),
    .SAddr(SAddr), .SBE(SBE), .SWE(SWE), .SRD(SRD),
    .SDataOut(SDataOut), .SBurst(SBurst),
    .SBurstFirst(SBurstFirst), .SBurstLast(SBurstLast),
    .SDataIn(SDataIn), .SWRAck(SWRAck), .SRDAck(SRDAck),
    .GrantValid(GrantValid), .GrantIdx(GrantIdx)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic we, input logic rd,
                       input logic [31:0] addr, input logic [11:0] burst);
    MWE[i]           = we;
    MRD[i]           = rd;
    MAddr[32*i +: 32] = addr;
    MBurst[12*i +: 12] = burst;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    MWE[1] = 1'b1;
    SDataIn = 32'h1234_5678;
    #3;
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL rst_gv got=%b exp=0", GrantValid); end
    tests++; if (GrantIdx !== 2'd0) begin fails++; $display("FAIL rst_gidx got=%0d exp=0", GrantIdx); end
    tests++; if (SWE !== 1'b0) begin fails++; $display("FAIL rst_swe got=%b exp=0", SWE); end
    tests++; if (SAddr !== 32'h0) begin fails++; $display("FAIL rst_saddr got=%h exp=0", SAddr); end
    tests++; if (MWRAck !== 4'b0) begin fails++; $display("FAIL rst_mwrack got=%b exp=0000", MWRAck); end
    tests++; if (MDataIn !== 32'h1234_5678) begin fails++; $display("FAIL rst_mdatain got=%h exp=12345678", MDataIn); end
    tick();
    tick();
    MWE[1] = 1'b0;
    nReset = 1'b1;
    #1;
  endtask

  task automatic test_single_read();
    set_m(2, 1'b0, 1'b1, 32'h100, 12'd0);
    #1;
    tests++; if (SRD !== 1'b0) begin fails++; $display("FAIL sr_srd_early got=%b exp=0", SRD); end
    tick();
    tests++; if (GrantValid !== 1'b1) begin fails++; $display("FAIL sr_gv got=%b exp=1", GrantValid); end
    tests++; if (GrantIdx !== 2'd2) begin fails++; $display("FAIL sr_gidx got=%0d exp=2", GrantIdx); end
    tests++; if (SRD !== 1'b1) begin fails++; $display("FAIL sr_srd got=%b exp=1", SRD); end
    tests++; if (SWE !== 1'b0) begin fails++; $display("FAIL sr_swe got=%b exp=0", SWE); end
    tests++; if (SAddr !== 32'h100) begin fails++; $display("FAIL sr_saddr got=%h exp=100", SAddr); end
    tests++; if (SBE !== 4'd3) begin fails++; $display("FAIL sr_sbe got=%h exp=3", SBE); end
    tests++; if (SDataOut !== 32'hD000_0002) begin fails++; $display("FAIL sr_sdo got=%h exp=d0000002", SDataOut); end
    SRDAck = 1'b1;
    SDataIn = 32'hCAFE_F00D;
    #1;
    tests++; if (MRDAck !== 4'b0100) begin fails++; $display("FAIL sr_mrdack got=%b exp=0100", MRDAck); end
    tests++; if (MWRAck !== 4'b0000) begin fails++; $display("FAIL sr_mwrack got=%b exp=0000", MWRAck); end
    tests++; if (MDataIn !== 32'hCAFE_F00D) begin fails++; $display("FAIL sr_mdi got=%h exp=cafef00d", MDataIn); end
    tick();
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL sr_idle got=%b exp=0", GrantValid); end
    tests++; if (MRDAck !== 4'b0000) begin fails++; $display("FAIL sr_idle_ack got=%b exp=0000", MRDAck); end
    set_m(2, 1'b0, 1'b0, 32'h0, 12'd0);
    SRDAck = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    int order[3] = '{0, 1, 3};
    nReset = 1'b0;
    #1;
    nReset = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h200, 12'd0);
    set_m(1, 1'b1, 1'b0, 32'h204, 12'd0);
    set_m(3, 1'b1, 1'b0, 32'h20C, 12'd0);
    #1;
    for (int j = 0; j < 3; j++) begin
      tick();
      tests++; if (GrantValid !== 1'b1) begin fails++; $display("FAIL rr_gv[%0d] got=%b exp=1", j, GrantValid); end
      tests++; if (int'(GrantIdx) != order[j]) begin fails++; $display("FAIL rr_gidx[%0d] got=%0d exp=%0d", j, GrantIdx, order[j]); end
      tests++; if (SAddr !== 32'h200 + 4*order[j]) begin fails++; $display("FAIL rr_saddr[%0d] got=%h exp=%h", j, SAddr, 32'h200 + 4*order[j]); end
      SWRAck = 1'b1;
      #1;
      tests++; if (MWRAck !== 4'(1 << order[j])) begin fails++; $display("FAIL rr_ack[%0d] got=%b exp=%b", j, MWRAck, 4'(1 << order[j])); end
      tick();
      tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL rr_bubble[%0d] got=%b exp=0", j, GrantValid); end
      MWE[order[j]] = 1'b0;
      SWRAck = 1'b0;
      #1;
    end
  endtask

  task automatic test_burst();
    set_m(1, 1'b1, 1'b0, 32'h300, 12'd4);
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd1) begin fails++; $display("FAIL bu_gidx got=%0d exp=1", GrantIdx); end
    tests++; if (SBurst !== 12'd4) begin fails++; $display("FAIL bu_sburst got=%0d exp=4", SBurst); end
    tests++; if (SBurstFirst !== 1'b0) begin fails++; $display("FAIL bu_sbf got=%b exp=0", SBurstFirst); end
    tests++; if (SBurstLast !== 1'b1) begin fails++; $display("FAIL bu_sbl got=%b exp=1", SBurstLast); end
    set_m(0, 1'b0, 1'b1, 32'h400, 12'd0);
    SWRAck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (GrantValid !== 1'b1 || GrantIdx !== 2'd1) begin fails++; $display("FAIL bu_hold[%0d] got=%b/%0d exp=1/1", k, GrantValid, GrantIdx); end
      tests++; if (MWRAck !== 4'b0010) begin fails++; $display("FAIL bu_ack[%0d] got=%b exp=0010", k, MWRAck); end
      tick();
    end
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL bu_end got=%b exp=0", GrantValid); end
    tests++; if (MWRAck !== 4'b0000) begin fails++; $display("FAIL bu_end_ack got=%b exp=0000", MWRAck); end
    SWRAck = 1'b0;
    MWE[1] = 1'b0;
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd0 || GrantValid !== 1'b1) begin fails++; $display("FAIL bu_next got=%b/%0d exp=1/0", GrantValid, GrantIdx); end
    tests++; if (SAddr !== 32'h400) begin fails++; $display("FAIL bu_next_addr got=%h exp=400", SAddr); end
    SRDAck = 1'b1;
    #1;
    tests++; if (MRDAck !== 4'b0001) begin fails++; $display("FAIL bu_next_ack got=%b exp=0001", MRDAck); end
    tick();
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL bu_next_end got=%b exp=0", GrantValid); end
    MRD[0] = 1'b0;
    SRDAck = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    set_m(1, 1'b0, 1'b1, 32'h500, 12'd0);
    set_m(2, 1'b0, 1'b1, 32'h600, 12'd0);
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd1) begin fails++; $display("FAIL bb_first got=%0d exp=1", GrantIdx); end
    SRDAck = 1'b1;
    tick();
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL bb_bubble got=%b exp=0", GrantValid); end
    SRDAck = 1'b0;
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd2 || GrantValid !== 1'b1) begin fails++; $display("FAIL bb_second got=%b/%0d exp=1/2", GrantValid, GrantIdx); end
    SRDAck = 1'b1;
    tick();
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL bb_bubble2 got=%b exp=0", GrantValid); end
    MRD[2] = 1'b0;
    SRDAck = 1'b0;
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd1 || GrantValid !== 1'b1) begin fails++; $display("FAIL bb_third got=%b/%0d exp=1/1", GrantValid, GrantIdx); end
    SRDAck = 1'b1;
    tick();
    MRD[1] = 1'b0;
    SRDAck = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_burst();
    set_m(3, 1'b1, 1'b0, 32'h700, 12'd8);
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd3 || GrantValid !== 1'b1) begin fails++; $display("FAIL rm_grant got=%b/%0d exp=1/3", GrantValid, GrantIdx); end
    SWRAck = 1'b1;
    tick();
    tick();
    tests++; if (SWE !== 1'b1 || GrantValid !== 1'b1) begin fails++; $display("FAIL rm_mid got=%b/%b exp=1/1", SWE, GrantValid); end
    nReset = 1'b0;
    #1;
    tests++; if (SWE !== 1'b0 || SRD !== 1'b0) begin fails++; $display("FAIL rm_strobe got=%b/%b exp=0/0", SWE, SRD); end
    tests++; if (GrantValid !== 1'b0 || GrantIdx !== 2'd0) begin fails++; $display("FAIL rm_state got=%b/%0d exp=0/0", GrantValid, GrantIdx); end
    tests++; if (MWRAck !== 4'b0000 || SAddr !== 32'h0) begin fails++; $display("FAIL rm_out got=%b/%h exp=0000/0", MWRAck, SAddr); end
    SWRAck = 1'b0;
    set_m(0, 1'b1, 1'b0, 32'h800, 12'd0);
    tick();
    nReset = 1'b1;
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd0 || GrantValid !== 1'b1) begin fails++; $display("FAIL rm_restart got=%b/%0d exp=1/0", GrantValid, GrantIdx); end
    SWRAck = 1'b1;
    tick();
    MWE[0] = 1'b0;
    SWRAck = 1'b0;
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd3 || GrantValid !== 1'b1) begin fails++; $display("FAIL rm_regrant got=%b/%0d exp=1/3", GrantValid, GrantIdx); end
    SWRAck = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests++; if (GrantValid !== 1'b1) begin fails++; $display("FAIL rm_full[%0d] got=%b exp=1", k, GrantValid); end
      tick();
    end
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL rm_full_end got=%b exp=0", GrantValid); end
    MWE[3] = 1'b0;
    SWRAck = 1'b0;
    #1;
  endtask

  task automatic test_abandon();
    set_m(0, 1'b0, 1'b1, 32'h900, 12'd0);
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd0 || GrantValid !== 1'b1) begin fails++; $display("FAIL ab_grant got=%b/%0d exp=1/0", GrantValid, GrantIdx); end
    MRD[0] = 1'b0;
    SRDAck = 1'b1;
    #1;
    tests++; if (SRD !== 1'b0 || MRDAck !== 4'b0000) begin fails++; $display("FAIL ab_noack got=%b/%b exp=0/0000", SRD, MRDAck); end
    tick();
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL ab_idle got=%b exp=0", GrantValid); end
    tests++; if (MRDAck !== 4'b0000) begin fails++; $display("FAIL ab_stray got=%b exp=0000", MRDAck); end
    SRDAck = 1'b0;
    #1;
  endtask

  task automatic test_dual_strobe();
    set_m(2, 1'b1, 1'b1, 32'hA00, 12'd2);
    #1;
    tick();
    tests++; if (GrantIdx !== 2'd2 || SWE !== 1'b1 || SRD !== 1'b1) begin fails++; $display("FAIL ds_fwd got=%0d/%b/%b exp=2/1/1", GrantIdx, SWE, SRD); end
    SWRAck = 1'b1;
    SRDAck = 1'b1;
    #1;
    tests++; if (MWRAck !== 4'b0100 || MRDAck !== 4'b0100) begin fails++; $display("FAIL ds_acks got=%b/%b exp=0100/0100", MWRAck, MRDAck); end
    tick();
    tests++; if (GrantValid !== 1'b1) begin fails++; $display("FAIL ds_once got=%b exp=1", GrantValid); end
    tick();
    tests++; if (GrantValid !== 1'b0) begin fails++; $display("FAIL ds_end got=%b exp=0", GrantValid); end
    MWE = '0;
    MRD = '0;
    SWRAck = 1'b0;
    SRDAck = 1'b0;
    #1;
  endtask

  initial begin
    nReset = 1'b0;
    MAddr = '0;
    MBE = '0;
    MWE = '0;
    MRD = '0;
    MDataOut = '0;
    MBurst = '0;
    MBurstFirst = 4'b0101;
    MBurstLast = 4'b1010;
    SDataIn = '0;
    SWRAck = 1'b0;
    SRDAck = 1'b0;
    for (int i = 0; i < N; i++) begin
      MBE[4*i +: 4] = 4'(i + 1);
      MDataOut[32*i +: 32] = 32'hD000_0000 + i;
    end
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst();
    test_back_to_back();
    test_reset_mid_burst();
    test_abandon();
    test_dual_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
